// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority picker: first set request bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  pick,
  output logic             any
);

  localparam int SUM_W = ID_W + 1;

  logic [N_REQ-1:0] rot_s;
  logic [ID_W-1:0]  off_s;
  logic [SUM_W-1:0] sum_s;

  // rotate rr_ptr down to bit 0, find the nearest set bit, then add the offset back modulo N_REQ
  always_comb begin
    rot_s = N_REQ'({req, req} >> rr_ptr);
    off_s = '0;
    any   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? ID_W'(k) : off_s;
      any   = any | rot_s[k];
    end
    sum_s = {1'b0, rr_ptr} + {1'b0, off_s};
    if (sum_s >= SUM_W'(N_REQ)) begin
      pick = ID_W'(sum_s - SUM_W'(N_REQ));
    end else begin
      pick = ID_W'(sum_s);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ byte producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = id_width(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      wfull,
  output logic                      winc,
  output logic [DATA_W-1:0]         wdata,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  localparam int CNT_W = cnt_width(MAX_BURST);

  arb_state_e        state_r;
  logic [ID_W-1:0]   grant_r;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [CNT_W-1:0]  beat_cnt_r;

  logic [ID_W-1:0]   pick_s;
  logic              any_s;
  logic              busy_s;
  logic              g_valid_s;
  logic              g_last_s;
  logic              xfer_s;
  logic              burst_end_s;
  logic [ID_W-1:0]   next_ptr_s;
  logic [DATA_W-1:0] lanes_s [N_REQ];

  fifo_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_r),
    .pick   (pick_s),
    .any    (any_s)
  );

  // unpack the byte lanes so the grant mux is a plain array index
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      lanes_s[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // granted-lane handshake and write-side outputs; nothing but wdata depends on req_data
  always_comb begin
    busy_s    = (state_r == ARB_BURST);
    g_valid_s = req_valid[grant_r];
    g_last_s  = req_last[grant_r];
    xfer_s    = busy_s & g_valid_s & ~wfull;
    req_ready = '0;
    if (busy_s) begin
      req_ready[grant_r] = ~wfull;
      wdata              = lanes_s[grant_r];
    end else begin
      wdata = '0;
    end
    winc        = xfer_s;
    burst_end_s = xfer_s & (g_last_s | (beat_cnt_r == CNT_W'(MAX_BURST - 1)));
    next_ptr_s  = (grant_r == ID_W'(N_REQ - 1)) ? '0 : grant_r + ID_W'(1);
  end

  assign busy     = busy_s;
  assign grant_id = grant_r;

  // grant FSM: pick in IDLE, count beats in BURST, advance rr_ptr past the finished grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ARB_IDLE;
      grant_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (any_s) begin
            grant_r    <= pick_s;
            beat_cnt_r <= '0;
            state_r    <= ARB_BURST;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_BURST: begin
          if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            if (burst_end_s) begin
              state_r  <= ARB_IDLE;
              rr_ptr_r <= next_ptr_s;
            end else begin
              state_r <= ARB_BURST;
            end
          end else begin
            state_r <= ARB_BURST;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: queue-driven producers, transaction-level round-robin reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          wfull = 1'b0;
  logic          winc;
  logic [DW-1:0] wdata;
  logic [1:0]    grant_id;
  logic          busy;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // producer queues: bit 8 = last flag, bits 7:0 = byte
  logic [8:0] mem [N][256];
  int hd [N];
  int tl [N];
  logic [N-1:0] en = '1;
  logic wfull_ctl = 1'b0;
  int wfull_pct = 0;

  int cyc = 0;
  logic s_winc, s_busy;
  logic [7:0] s_wdata;
  logic [1:0] s_grant;
  logic [N-1:0] s_ready;
  int log_id[$];
  int log_data[$];
  int exp_id[$];
  int exp_data[$];
  int viol = 0;
  int model_ptr = 0;
  int busy_cycles, first_busy, last_busy;

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
  endtask

  task automatic push_pkt(input int r, input int base, input int len);
    for (int k = 0; k < len; k++) begin
      mem[r][tl[r]][8]   = (k == len - 1);
      mem[r][tl[r]][7:0] = 8'(base + k);
      tl[r]++;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (hd[i] != tl[i]) return 1'b0;
    return 1'b1;
  endfunction

  // one clock: drive at negedge, sample #1 later, pop whatever the DUT accepted
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = en[i] && (hd[i] < tl[i]);
      req_data[i*DW +: DW] = mem[i][hd[i]][7:0];
      req_last[i]          = mem[i][hd[i]][8] & req_valid[i];
    end
    wfull = wfull_ctl | (int'($urandom_range(0, 99)) < wfull_pct);
    #1;
    cyc++;
    s_winc = winc; s_busy = busy; s_wdata = wdata; s_grant = grant_id; s_ready = req_ready;
    acc = req_valid & req_ready;
    if (busy) begin
      busy_cycles++;
      if (first_busy < 0) first_busy = cyc;
      last_busy = cyc;
    end
    if (!busy && req_ready != '0) viol++;
    if ((req_ready & ~(N'(1) << grant_id)) != '0) viol++;
    if (winc) begin
      if (wfull) viol++;
      if (acc != (N'(1) << grant_id) || wdata != mem[grant_id][hd[grant_id]][7:0]) viol++;
      log_id.push_back(int'(grant_id));
      log_data.push_back(int'(wdata));
    end else if (acc != '0) begin
      viol++;
    end
    for (int i = 0; i < N; i++) if (acc[i]) hd[i]++;
  endtask

  // reference: every loaded requester is valid; grants rotate, each burst takes up to MB bytes or to last
  task automatic build_expected();
    int h [N];
    int g, cnt;
    bit lst;
    exp_id.delete();
    exp_data.delete();
    for (int i = 0; i < N; i++) h[i] = hd[i];
    for (int guard = 0; guard < 1000; guard++) begin
      g = -1;
      for (int k = N - 1; k >= 0; k--) begin
        int r = (model_ptr + k) % N;
        if (en[r] && h[r] < tl[r]) g = r;
      end
      if (g < 0) break;
      cnt = 0;
      lst = 1'b0;
      while (!lst && cnt < MB && h[g] < tl[g]) begin
        exp_id.push_back(g);
        exp_data.push_back(int'(mem[g][h[g]][7:0]));
        lst = mem[g][h[g]][8];
        h[g]++;
        cnt++;
      end
      model_ptr = (g + 1) % N;
    end
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (all_empty() && !s_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    wfull = 1'b0;
    wfull_ctl = 1'b0;
    clear_queues();
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_queues();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({winc, req_ready, busy, grant_id, wdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: winc=%0b ready=%b busy=%0b grant=%0d wdata=%h, required all 0",
                 winc, req_ready, busy, grant_id, wdata);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if ({s_winc, s_ready, s_busy, s_grant, s_wdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: winc=%0b ready=%b busy=%0b grant=%0d wdata=%h, required all 0",
                 s_winc, s_ready, s_busy, s_grant, s_wdata);
      end
    end
  endtask

  task automatic test_single_packet();
    bit ok;
    push_pkt(1, 'hA0, 4);
    build_expected();
    step();
    n_checks++;
    if (s_busy !== 1'b0 || s_winc !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: busy=%0b winc=%0b in request cycle, required 0 0", s_busy, s_winc);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (s_busy !== 1'b1 || s_winc !== 1'b1 || s_grant !== 2'd1 || s_wdata !== 8'(8'hA0 + k)) begin
        n_fail++;
        $display("FAIL single_beat%0d: busy=%0b winc=%0b grant=%0d wdata=%h, required 1 1 1 %h",
                 k, s_busy, s_winc, s_grant, s_wdata, 8'(8'hA0 + k));
      end
    end
    step();
    n_checks++;
    if (s_busy !== 1'b0 || s_winc !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: busy=%0b winc=%0b after last, required 0 0", s_busy, s_winc);
    end
    // rr_ptr now 2: with requesters 0 and 2 both valid, 2 wins
    push_pkt(0, 'h50, 1);
    push_pkt(2, 'h60, 1);
    build_expected();
    step();
    step();
    n_checks++;
    if (s_grant !== 2'd2 || s_winc !== 1'b1 || s_wdata !== 8'h60) begin
      n_fail++;
      $display("FAIL single_rr_ptr: grant=%0d winc=%0b wdata=%h, required 2 1 60", s_grant, s_winc, s_wdata);
    end
    drain(50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_drain: timeout, required drain within 50 cycles");
    end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset(2);
    log_id.delete();
    log_data.delete();
    for (int r = 0; r < N; r++) begin
      push_pkt(r, 'h80 + 16 * r, 2);
      push_pkt(r, 'h88 + 16 * r, 2);
    end
    build_expected();
    busy_cycles = 0;
    first_busy = -1;
    last_busy = -1;
    drain(200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fair_drain: timeout, required drain within 200 cycles");
    end
    n_checks++;
    if (log_id.size() !== exp_id.size()) begin
      n_fail++;
      $display("FAIL fair_count: got %0d writes, required %0d", log_id.size(), exp_id.size());
    end else begin
      for (int i = 0; i < exp_id.size(); i++) begin
        n_checks++;
        if (log_id[i] !== exp_id[i] || log_data[i] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL fair_order[%0d]: got id %0d data %h, required id %0d data %h",
                   i, log_id[i], log_data[i], exp_id[i], exp_data[i]);
        end
      end
    end
    n_checks++;
    if (busy_cycles !== 16 || (last_busy - first_busy + 1) !== 23) begin
      n_fail++;
      $display("FAIL fair_bubbles: busy %0d span %0d, required busy 16 span 23",
               busy_cycles, last_busy - first_busy + 1);
    end
  endtask

  task automatic test_burst_cap();
    bit ok;
    log_id.delete();
    log_data.delete();
    push_pkt(2, 'h20, 12);
    step();
    push_pkt(0, 'h50, 3);
    exp_id.delete();
    exp_data.delete();
    for (int k = 0; k < 8; k++) begin exp_id.push_back(2); exp_data.push_back('h20 + k); end
    for (int k = 0; k < 3; k++) begin exp_id.push_back(0); exp_data.push_back('h50 + k); end
    for (int k = 8; k < 12; k++) begin exp_id.push_back(2); exp_data.push_back('h20 + k); end
    model_ptr = 3;
    drain(100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cap_drain: timeout, required drain within 100 cycles");
    end
    n_checks++;
    if (log_id.size() !== exp_id.size()) begin
      n_fail++;
      $display("FAIL cap_count: got %0d writes, required %0d", log_id.size(), exp_id.size());
    end else begin
      for (int i = 0; i < exp_id.size(); i++) begin
        n_checks++;
        if (log_id[i] !== exp_id[i] || log_data[i] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL cap_order[%0d]: got id %0d data %h, required id %0d data %h",
                   i, log_id[i], log_data[i], exp_id[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int stalls = 0;
    bit after = 1'b0;
    bit done = 1'b0;
    log_id.delete();
    log_data.delete();
    push_pkt(3, 'h30, 5);
    build_expected();
    for (int i = 0; i < 40 && !done; i++) begin
      wfull_ctl = (log_id.size() == 2 && stalls < 3);
      step();
      if (wfull_ctl) begin
        stalls++;
        n_checks++;
        if (s_winc !== 1'b0 || s_ready !== '0 || s_busy !== 1'b1 || s_grant !== 2'd3) begin
          n_fail++;
          $display("FAIL bp_stall: winc=%0b ready=%b busy=%0b grant=%0d, required 0 0000 1 3",
                   s_winc, s_ready, s_busy, s_grant);
        end
      end else if (stalls == 3 && !after) begin
        after = 1'b1;
        n_checks++;
        if (s_winc !== 1'b1 || s_wdata !== 8'h32) begin
          n_fail++;
          $display("FAIL bp_resume: winc=%0b wdata=%h, required 1 32", s_winc, s_wdata);
        end
      end
      done = all_empty() && !s_busy;
    end
    wfull_ctl = 1'b0;
    n_checks++;
    if (!done || stalls !== 3) begin
      n_fail++;
      $display("FAIL bp_drain: done=%0b stalls=%0d, required 1 3", done, stalls);
    end
    n_checks++;
    if (log_id.size() !== exp_id.size()) begin
      n_fail++;
      $display("FAIL bp_count: got %0d writes, required %0d", log_id.size(), exp_id.size());
    end else begin
      for (int i = 0; i < exp_id.size(); i++) begin
        n_checks++;
        if (log_id[i] !== exp_id[i] || log_data[i] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL bp_order[%0d]: got id %0d data %h, required id %0d data %h",
                   i, log_id[i], log_data[i], exp_id[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    log_id.delete();
    log_data.delete();
    push_pkt(1, 'h70, 6);
    for (int i = 0; i < 20 && log_id.size() < 3; i++) step();
    n_checks++;
    if (log_id.size() !== 3) begin
      n_fail++;
      $display("FAIL rstmid_prefix: got %0d writes, required 3", log_id.size());
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (winc !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_immediate: winc=%0b busy=%0b ready=%b grant=%0d, required 0 0 0000 0",
               winc, busy, req_ready, grant_id);
    end
    req_valid = '0;
    clear_queues();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    push_pkt(1, 'h78, 1);
    push_pkt(3, 'h7C, 1);
    build_expected();
    step();
    step();
    n_checks++;
    if (s_grant !== 2'd1 || s_winc !== 1'b1 || s_wdata !== 8'h78) begin
      n_fail++;
      $display("FAIL rstmid_regrant: grant=%0d winc=%0b wdata=%h, required 1 1 78", s_grant, s_winc, s_wdata);
    end
    drain(50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstmid_drain: timeout, required drain within 50 cycles");
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int round = 0; round < 8; round++) begin
      log_id.delete();
      log_data.delete();
      clear_queues();
      for (int r = 0; r < N; r++) begin
        int npk = int'($urandom_range(0, 3));
        for (int p = 0; p < npk; p++) push_pkt(r, int'($urandom_range(0, 255)), int'($urandom_range(1, 12)));
      end
      build_expected();
      wfull_pct = int'($urandom_range(0, 50));
      drain(3000, ok);
      wfull_pct = 0;
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand%0d_drain: timeout, required drain within 3000 cycles", round);
      end
      n_checks++;
      if (log_id.size() !== exp_id.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d writes, required %0d", round, log_id.size(), exp_id.size());
      end else begin
        for (int i = 0; i < exp_id.size(); i++) begin
          n_checks++;
          if (log_id[i] !== exp_id[i] || log_data[i] !== exp_data[i]) begin
            n_fail++;
            $display("FAIL rand%0d_order[%0d]: got id %0d data %h, required id %0d data %h",
                     round, i, log_id[i], log_data[i], exp_id[i], exp_data[i]);
          end
        end
      end
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL protocol: %0d handshake violations seen, required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_fairness();
    test_burst_cap();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
